fifo_rd_drain: RTL and testbench

Read-side drain controller for the team's FIFO: sits in the read clock domain, pops words from the FIFO read port (single-cycle RAM read latency) and presents them downstream as a valid/ready stream with full throughput. A 2-entry output buffer absorbs the RAM latency, so back-pressure on `m_ready` never drops or duplicates a word. Also provides a flush and a popped-word counter for debug and status.

---
 rtl/fifo_rd_drain.sv | 116 +++++++++++
 tb/tb_fifo_rd_drain.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_drain
//  Purpose  : Read-side drain controller for a FIFO with single-cycle RAM
//             read latency. Pops words from the FIFO read port and presents
//             them as a full-throughput valid/ready stream. A 2-entry output
//             buffer absorbs the RAM latency so that back-pressure never
//             drops or duplicates a word. Provides a flush and a counter of
//             delivered words.
//  Ports    :
//      rd_clk        in   read-domain clock, rising-edge
//      reset         in   synchronous active-high reset (priority over flush)
//      enable        in   1 = allowed to issue new pops
//      flush         in   discard buffered and in-flight words
//      fifo_empty_n  in   FIFO holds at least one word
//      fifo_rd_en    out  pop strobe to FIFO
//      fifo_rdata    in   FIFO data, valid the cycle after fifo_rd_en
//      m_valid       out  stream valid
//      m_data        out  stream data (oldest first)
//      m_ready       in   downstream accept
//      word_count    out  delivered-word counter, wraps
//      busy          out  buffer non-empty or pop in flight
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);

    localparam logic [1:0] c_FULL = 2'd2;

    // Output buffer: buf0 is always the head of the stream.
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [1:0]            w_base;

    assign w_pop = (cnt_q != 2'd0) && m_ready;

    // Occupancy counts words already in the buffer plus the one the RAM is
    // returning, so a pop is only issued when a slot is guaranteed next cycle.
    assign w_occ = cnt_q + {1'b0, inflight_q};

    assign fifo_rd_en = !reset && enable && !flush && fifo_empty_n
                        && ((w_occ < c_FULL) || w_pop);

    always_comb begin
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        w_base       = cnt_q;
        inflight_d   = fifo_rd_en;
        word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, w_pop};

        // Head removal first; the capture slot is computed after the shift.
        if (w_pop) begin
            buf0_d = buf1_q;
            w_base = cnt_q - 2'd1;
        end

        if (inflight_q) begin
            if (w_base == 2'd0) begin
                buf0_d = fifo_rdata;
            end else begin
                buf1_d = fifo_rdata;
            end
        end

        cnt_d = w_base + {1'b0, inflight_q};

        // Flush drops everything held, including the word arriving now.
        if (flush) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            buf0_q       <= '0;
            buf1_q       <= '0;
            cnt_q        <= 2'd0;
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    assign m_valid    = (cnt_q != 2'd0);
    assign m_data     = buf0_q;
    assign word_count = word_count_q;
    assign busy       = (cnt_q != 2'd0) || inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_drain
//  Purpose  : Self-checking bench for fifo_rd_drain. A FIFO model feeds the
//             DUT; every word loaded is pushed onto an expected queue, and a
//             monitor pops and compares on each accepted beat. A second DUT
//             with a 4-bit counter shares all inputs to observe wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rd_drain;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        fifo_empty_n;
    logic        fifo_rd_en;
    logic [15:0] fifo_rdata;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [15:0] word_count;
    logic        busy;

    logic        rd_en4;
    logic        m_valid4;
    logic [15:0] m_data4;
    logic [3:0]  word_count4;
    logic        busy4;

    fifo_rd_drain #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .rd_clk       (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .fifo_empty_n (fifo_empty_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rdata   (fifo_rdata),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .word_count   (word_count),
        .busy         (busy)
    );

    fifo_rd_drain #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .rd_clk       (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .fifo_empty_n (fifo_empty_n),
        .fifo_rd_en   (rd_en4),
        .fifo_rdata   (fifo_rdata),
        .m_valid      (m_valid4),
        .m_data       (m_data4),
        .m_ready      (m_ready),
        .word_count   (word_count4),
        .busy         (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_empty_n = (rd_ptr < wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [$];
    int          total     = 0;
    int          bad       = 0;
    int          delivered = 0;
    int          cyc       = 0;
    int          rd_cnt    = 0;
    int          first_rd  = -1;
    int          first_v   = -1;
    bit          track_lat = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load(input int n, input logic [15:0] start, input bit rnd);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 16'($urandom) : start + 16'(i);
            mem[wr_ptr] = w;
            exp_q.push_back(w);
            wr_ptr++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy && !fifo_empty_n) break;
            cycles(1);
        end
        check_eq("drain_complete", {exp_q.size() == 0, busy, fifo_empty_n}, 32'b100);
    endtask

    task automatic drop_flushed(output int n);
        n = exp_q.size() - (wr_ptr - rd_ptr);
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                check_eq("rd_en_while_empty", fifo_empty_n, 1);
            end
            if (track_lat && fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (track_lat && m_valid && first_v < 0) first_v = cyc;
            if (prev_stall && m_valid) check_eq("data_hold", m_data, prev_data);
            if (dut.inflight_q && dut.cnt_q == 2'd2 && !(m_valid && m_ready)) begin
                bad++;
                $display("FAIL overflow: capture with cnt=%0d pop=0", dut.cnt_q);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", m_data);
                end else begin
                    check_eq("beat_data", m_data, exp_q.pop_front());
                end
                delivered++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- stimulus ----------------
    int n_disc;
    int d0;

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        cycles(3);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_word_count", word_count, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;
        cycles(1);

        // 8 words, no back-pressure
        track_lat = 1;
        m_ready   = 1'b1;
        load(8, 16'h0001, 0);
        wait_drain();
        track_lat = 0;
        check_eq("latency", first_v - first_rd, 2);
        check_eq("count_after_8", word_count, 8);
        check_eq("busy_after_8", busy, 0);

        // stall for 10 cycles
        m_ready = 1'b0;
        rd_cnt  = 0;
        load(8, 16'h0001, 0);
        cycles(10);
        check_eq("stall_pops", rd_cnt, 2);
        check_eq("stall_head", m_data, 16'h0001);
        check_eq("stall_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_drain();
        check_eq("count_after_16", word_count, 16);

        // enable dropped with 2 buffered words
        m_ready = 1'b0;
        load(6, 16'h0010, 0);
        cycles(5);
        enable  = 1'b0;
        m_ready = 1'b1;
        d0      = delivered;
        rd_cnt  = 0;
        cycles(6);
        check_eq("disable_delivered", delivered - d0, 2);
        check_eq("disable_pops", rd_cnt, 0);
        check_eq("disable_valid", m_valid, 0);
        enable = 1'b1;
        wait_drain();

        // flush with a full buffer
        m_ready = 1'b0;
        load(6, 16'h0020, 0);
        cycles(5);
        check_eq("pre_flush_busy", busy, 1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check_eq("flush_valid", m_valid, 0);
        check_eq("flush_busy", busy, 0);
        drop_flushed(n_disc);
        check_eq("flush_full_discards", n_disc, 2);
        m_ready = 1'b1;
        wait_drain();

        // flush while a word is in flight
        m_ready = 1'b0;
        load(4, 16'h0030, 0);
        cycles(1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check_eq("flush2_busy", busy, 0);
        drop_flushed(n_disc);
        check_eq("flush_inflight_discards", n_disc, 1);
        m_ready = 1'b1;
        wait_drain();

        // random back-pressure, 1000 words
        load(1000, 16'h0000, 1);
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycles(1);
        end
        m_ready = 1'b1;
        wait_drain();
        check_eq("count_1029", word_count, 1029);
        check_eq("count4_1029", word_count4, 5);

        // counter wrap on the 4-bit build
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        check_eq("count4_reset", word_count4, 0);
        load(20, 16'h0100, 0);
        wait_drain();
        check_eq("count4_wrap", word_count4, 4);
        check_eq("count_20", word_count, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
